// File: rtl/jtag_dr_bank.sv
// jtag_dr_bank: JTAG DR shift chain with IDCODE, BYPASS, BSR and N_USER user data registers.
module jtag_dr_bank #(
    parameter int              DR_W       = 32,
    parameter int              IR_W       = 4,
    parameter int              N_USER     = 4,
    parameter logic [DR_W-1:0] ID_CODE    = 32'h1000_0001,
    parameter logic [IR_W-1:0] INSTR_ID   = 4'h1,
    parameter logic [IR_W-1:0] INSTR_BSR  = 4'h2,
    parameter logic [IR_W-1:0] INSTR_USR0 = 4'h4,
    parameter logic [DR_W-1:0] USER_RST   = '0
) (
    input  logic                   i_tclk,
    input  logic                   i_trst_n,
    input  logic                   i_tdi,
    input  logic                   i_stateIsCaptureDr,
    input  logic                   i_stateIsShiftDr,
    input  logic                   i_stateIsUpdateDr,
    input  logic [IR_W-1:0]        i_instrReg,
    input  logic [DR_W-1:0]        i_bsr,
    output logic                   o_tdo,
    output logic [N_USER*DR_W-1:0] o_userData,
    output logic [N_USER-1:0]      o_userUpdate,
    output logic                   o_userSel
);
    localparam int UW = N_USER > 1 ? $clog2(N_USER) : 1;

    logic [DR_W-1:0]              chain;
    logic                         bypass_q;
    logic [N_USER-1:0][DR_W-1:0]  user_q;
    logic [N_USER-1:0]            upd_q;
    logic [IR_W-1:0]              usr_off;
    logic [UW-1:0]                uidx;
    logic                         is_id, is_bsr, is_usr, is_byp;
    logic [DR_W-1:0]              cap_val;

    if (!ID_CODE[0]) begin : g_id_chk
        $error("jtag_dr_bank: ID_CODE bit 0 must be 1");
    end

    // All-ones always means BYPASS, even if it falls inside the USER opcode range
    always_comb begin
        usr_off = i_instrReg - INSTR_USR0;
        uidx    = usr_off[UW-1:0];
        is_id   = i_instrReg == INSTR_ID && !(&i_instrReg);
        is_bsr  = i_instrReg == INSTR_BSR && !(&i_instrReg);
        is_usr  = !(&i_instrReg) && i_instrReg >= INSTR_USR0 && {1'b0, usr_off} < (IR_W+1)'(N_USER);
        is_byp  = !(is_id || is_bsr || is_usr);
        cap_val = is_id ? ID_CODE : is_bsr ? i_bsr : is_usr ? user_q[uidx] : chain;
    end

    always_ff @(posedge i_tclk or negedge i_trst_n) begin
        if (!i_trst_n) begin
            chain    <= '0;
            bypass_q <= 1'b0;
            user_q   <= {N_USER{USER_RST}};
            upd_q    <= '0;
        end else begin
            upd_q <= '0;
            if (i_stateIsCaptureDr) begin
                chain    <= cap_val;
                bypass_q <= 1'b0;
            end else if (i_stateIsShiftDr) begin
                if (is_byp)
                    bypass_q <= i_tdi;
                else
                    chain <= {i_tdi, chain[DR_W-1:1]};
            end else if (i_stateIsUpdateDr && is_usr) begin
                user_q[uidx] <= chain;
                upd_q[uidx]  <= 1'b1;
            end
        end
    end

    assign o_tdo        = is_byp ? bypass_q : chain[0];
    assign o_userData   = user_q;
    assign o_userUpdate = upd_q;
    assign o_userSel    = is_usr;
endmodule

// File: tb/tb_jtag_dr_bank.sv
// tb_jtag_dr_bank: directed scan sequences; TDO bits are scoreboarded and checked by a separate monitor.
module tb_jtag_dr_bank;
    logic         clk = 0, trst_n = 0, tdi = 0, cap = 0, sft = 0, upd = 0;
    logic [3:0]   ir  = 4'h1;
    logic [31:0]  bsr = '0;
    logic         tdo, usel;
    logic [127:0] udata;
    logic [3:0]   ustb;
    int           tests = 0, fails = 0;

    typedef struct {string nm; logic v;} exp_t;
    exp_t q[$];

    always #5 clk = ~clk;

    jtag_dr_bank dut (
        .i_tclk(clk), .i_trst_n(trst_n), .i_tdi(tdi),
        .i_stateIsCaptureDr(cap), .i_stateIsShiftDr(sft), .i_stateIsUpdateDr(upd),
        .i_instrReg(ir), .i_bsr(bsr), .o_tdo(tdo), .o_userData(udata),
        .o_userUpdate(ustb), .o_userSel(usel)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(string nm, logic [127:0] act, logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic capture(logic [3:0] op);
        ir  = op;
        cap = 1;
        step();
        cap = 0;
    endtask

    task automatic shift_bit(logic b, logic e, string nm);
        sft = 1;
        tdi = b;
        q.push_back('{nm, e});
        step();
        sft = 0;
    endtask

    task automatic shift_word(logic [31:0] din, logic [31:0] ex, string nm);
        for (int i = 0; i < 32; i++) shift_bit(din[i], ex[i], nm);
    endtask

    // TDO monitor: one expected bit per Shift-DR cycle, sampled mid-cycle
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (sft && q.size() > 0) begin
            e = q.pop_front();
            check(e.nm, {127'b0, tdo}, {127'b0, e.v});
        end
    end

    initial begin
        logic [127:0] u2;
        u2 = {32'h0, 32'hDEAD_BEEF, 64'h0};
        repeat (2) @(posedge clk);
        #1;
        check("rst_tdo", tdo, 0);
        check("rst_udata", udata, 0);
        check("rst_strobe", ustb, 0);
        trst_n = 1;
        step();
        // IDCODE
        capture(4'h1);
        check("t1_usel", usel, 0);
        shift_word(32'h0, 32'h1000_0001, "t1_idcode");
        // BYPASS and unknown opcode
        capture(4'hF);
        shift_bit(1, 0, "t2_byp0"); shift_bit(0, 1, "t2_byp1");
        shift_bit(1, 0, "t2_byp2"); shift_bit(1, 1, "t2_byp3");
        capture(4'hA);
        shift_bit(1, 0, "t2_unk0"); shift_bit(0, 1, "t2_unk1");
        shift_bit(1, 0, "t2_unk2"); shift_bit(1, 1, "t2_unk3");
        // USER2 write / readback
        capture(4'h6);
        check("t3_usel", usel, 1);
        shift_word(32'hDEAD_BEEF, 32'h0, "t3_shift_in");
        upd = 1;
        step();
        upd = 0;
        check("t3_data", udata, u2);
        check("t3_strobe", ustb, 4'b0100);
        step();
        check("t3_strobe_clr", ustb, 0);
        capture(4'h6);
        shift_word(32'h0, 32'hDEAD_BEEF, "t3_readback");
        check("t3_others", udata, u2);
        // BSR sample, update ignored
        bsr = 32'h0F0F_1234;
        capture(4'h2);
        shift_word(32'h0, 32'h0F0F_1234, "t4_bsr");
        upd = 1;
        step();
        upd = 0;
        check("t4_strobe", ustb, 0);
        check("t4_udata", udata, u2);
        // async reset mid-shift of USER1
        capture(4'h5);
        for (int i = 0; i < 10; i++) shift_bit(1, 0, "t5_pre");
        sft = 1;
        #2 trst_n = 0;
        #1;
        check("t5_udata", udata, 0);
        check("t5_strobe", ustb, 0);
        check("t5_tdo", tdo, 0);
        sft = 0;
        step();
        trst_n = 1;
        repeat (3) step();
        check("t5_no_update", udata, 0);
        check("t5_no_strobe", ustb, 0);
        // pending strobe dropped by reset
        capture(4'h4);
        shift_word(32'h1234_5678, 32'h0, "t5_u0_shift");
        upd = 1;
        step();
        upd = 0;
        check("t5_u0_strobe", ustb, 4'b0001);
        #2 trst_n = 0;
        #1;
        check("t5_strobe_drop", ustb, 0);
        check("t5_u0_cleared", udata, 0);
        step();
        trst_n = 1;
        step();
        // Capture beats Shift; idle holds
        ir  = 4'h1;
        cap = 1;
        sft = 1;
        tdi = 0;
        step();
        cap = 0;
        sft = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("t6_idle_tdo", tdo, 1);
        end
        shift_word(32'h0, 32'h1000_0001, "t6_after_idle");
        step();
        check("queue_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
